// File: rtl/hub_link_fifo.sv
// Elastic first-word-fall-through buffer on one hub channel, placed ahead of the
// inter-FPGA link serializer. It also reports occupancy, almost-full and a sticky high-water mark.
module hub_link_fifo #(
  parameter int CHANNEL_WIDTH      = 64,
  parameter int DEST_WIDTH         = 8,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CHANNEL_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   max_count,
  input  logic                     clear_max
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PAYLOAD_WIDTH = CHANNEL_WIDTH - DEST_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(ALMOST_FULL_THRESH);

  logic [CHANNEL_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic [CW-1:0]            r_max_count;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_in_ready;
  logic                     w_out_valid;
  logic [CW-1:0]            w_count_next;
  logic [CW-1:0]            w_max_next;
  logic [DEST_WIDTH-1:0]    w_in_dest;
  logic [PAYLOAD_WIDTH-1:0] w_in_payload;
  logic [CHANNEL_WIDTH-1:0] w_wr_word;

  // Destination field is carried verbatim; no routing decision is made here.
  assign w_in_dest    = in_data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
  assign w_in_payload = in_data[PAYLOAD_WIDTH-1:0];
  assign w_wr_word    = {w_in_dest, w_in_payload};

  // Handshake flags come from registered occupancy only, so neither side sees a
  // combinational path from the other; a pop while full frees space next cycle.
  assign w_in_ready  = (r_count != DEPTH_C);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Clearing loads the upcoming occupancy so a clear issued mid-burst still tracks.
  always_comb begin
    w_max_next = r_max_count;
    if (clear_max) begin
      w_max_next = w_count_next;
    end else if (w_count_next > r_max_count) begin
      w_max_next = w_count_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count     <= w_count_next;
      r_max_count <= w_max_next;
    end
  end

  // Storage holds no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign count       = r_count;
  assign almost_full = (r_count >= THRESH_C);
  assign max_count   = r_max_count;

endmodule

// File: tb/tb_hub_link_fifo.sv
// Scoreboard bench for hub_link_fifo: directed scenarios followed by a random phase,
// checked every cycle against a queue-based reference model.
module tb_hub_link_fifo;

  localparam int W  = 64;
  localparam int D  = 8;
  localparam int TH = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         clear_max = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [3:0]   count;
  logic         almost_full;
  logic [3:0]   max_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int           m_max = 0;
  bit           m_push_pl = 1'b0;

  hub_link_fifo #(
    .CHANNEL_WIDTH(W),
    .DEST_WIDTH(8),
    .DEPTH(D),
    .ALMOST_FULL_THRESH(TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .almost_full(almost_full),
    .max_count(max_count),
    .clear_max(clear_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: outputs are compared on the falling edge, then the
  // transaction that the next rising edge will perform is applied to the model.
  always @(negedge clk) begin
    int  sz;
    int  nxt;
    bit  push;
    bit  pop;
    if (!reset) begin
      exp_q.delete();
      m_max = 0;
    end
    sz = exp_q.size();
    chk("sb_count", 64'(count), 64'(sz));
    chk("sb_in_ready", 64'(in_ready), 64'(sz != D));
    chk("sb_out_valid", 64'(out_valid), 64'(sz != 0));
    chk("sb_almost_full", 64'(almost_full), 64'(sz >= TH));
    chk("sb_max_count", 64'(max_count), 64'(m_max));
    if (sz != 0) chk("sb_out_data", out_data, exp_q[0]);
    else         chk("sb_out_data_empty", out_data, 64'd0);
    push = reset && in_valid && (sz != D);
    pop  = reset && out_ready && (sz != 0);
    m_push_pl = push;
    if (pop) begin
      $display("[TB] pop  data=%016h occ=%0d", exp_q[0], sz);
      void'(exp_q.pop_front());
    end
    if (push) exp_q.push_back(in_data);
    if (reset) begin
      nxt = exp_q.size();
      m_max = clear_max ? nxt : ((nxt > m_max) ? nxt : m_max);
    end
  end

  initial begin
    // Reset then idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_max", 64'(max_count), 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // Single word
    in_data = 64'hA5A5_0000_0000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_count", 64'(count), 64'd1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'hA5A5_0000_0000_0001);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", 64'(count), 64'd0);
    chk("single_pop_valid", 64'(out_valid), 64'd0);

    // Fill to full, hold off a ninth word, then drain
    for (int i = 1; i <= D; i++) begin
      in_data = 64'(i);
      in_valid = 1'b1;
      step();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_almost_full", 64'(almost_full), 64'(i >= TH));
      chk("fill_in_ready", 64'(in_ready), 64'(i != D));
    end
    in_data = 64'd9;
    step();
    chk("full_hold_count", 64'(count), 64'(D));
    out_ready = 1'b1;
    step();
    chk("pop_while_full_count", 64'(count), 64'(D - 1));
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (D - 1) step();
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // Simultaneous push/pop at occupancy 3
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(100 + i);
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 64'(103 + k);
      step();
      chk("stream_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    chk("stream_drain", 64'(count), 64'd0);

    // High-water mark
    clear_max = 1'b1;
    step();
    clear_max = 1'b0;
    chk("hw_clear_idle", 64'(max_count), 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 64'hB000 + 64'(i);
      step();
    end
    in_valid = 1'b0;
    chk("hw_peak5", 64'(max_count), 64'd5);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("hw_at2_count", 64'(count), 64'd2);
    chk("hw_at2_max", 64'(max_count), 64'd5);
    clear_max = 1'b1;
    step();
    clear_max = 1'b0;
    chk("hw_clear_busy", 64'(max_count), 64'd2);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 64'hB100 + 64'(i);
      step();
    end
    in_valid = 1'b0;
    chk("hw_peak4", 64'(max_count), 64'd4);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a burst
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'hC000 + 64'(i);
      step();
    end
    in_valid = 1'b0;
    chk("mid_count_before", 64'(count), 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_data", out_data, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    in_data = 64'h1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_first_word", out_data, 64'h1);
    chk("post_rst_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random traffic: fill-biased first half, drain-biased second half
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !m_push_pl)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = {$urandom, $urandom};
      end
      if (c < 300) out_ready = ($urandom_range(0, 2) == 0);
      else         out_ready = ($urandom_range(0, 2) != 0);
      clear_max = ($urandom_range(0, 15) == 0);
      step();
    end

    in_valid = 1'b0;
    clear_max = 1'b0;
    out_ready = 1'b1;
    repeat (D + 1) step();
    chk("final_empty", 64'(count), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hub_link_fifo.md
Name: hub_link_fifo

Overview:
- Elastic buffer on one 64-bit hub channel, placed directly downstream of a root hub tx port, before the inter-FPGA link serializer; one instance per child link plus one on the local port.
- Absorbs link back-pressure so the hub's per-port tx_ready deasserts only when the buffer is genuinely full.
- Exposes occupancy, an almost-full flag and a sticky high-water mark for link-delay tuning and debug.

Parameters:
- CHANNEL_WIDTH, 64, word width; top DEST_WIDTH bits carry the destination and are passed through untouched.
- DEST_WIDTH, 8, destination field width; informational only, no filtering.
- DEPTH, 8, number of entries; power of 2, minimum 2.
- ALMOST_FULL_THRESH, 6, almost_full asserts when count >= this value; legal range 1..DEPTH.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  CHANNEL_WIDTH  word from hub tx_data slice.
- in_valid  input  1  hub tx_valid.
- in_ready  output  1  to hub tx_ready.
- out_data  output  CHANNEL_WIDTH  word toward link.
- out_valid  output  1  word available.
- out_ready  input  1  link accepts word.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_THRESH.
- max_count  output  $clog2(DEPTH)+1  sticky high-water mark of count.
- clear_max  input  1  synchronous clear of max_count.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, max_count=0. Resulting outputs: out_valid=0, in_ready=1, almost_full=0, out_data=0. Storage array is not reset.
- Mid-operation reset: all buffered words are discarded. Deassertion is treated synchronously to clk. The first push is accepted on the first rising edge with reset=1.
- Push: occurs when in_valid & in_ready at a rising edge. It writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural wrap; DEPTH is a power of 2).
- Pop: occurs when out_valid & out_ready at a rising edge, and increments rd_ptr modulo DEPTH.
- out_data = mem[rd_ptr] when count != 0, else 0 (first-word-fall-through).
- out_valid = (count != 0), registered-state derived. There is no combinational path from in_valid.
- Latency: a word pushed at edge N has out_valid=1 and out_data valid after edge N, so the earliest pop is edge N+1.
- in_ready = (count != DEPTH), derived from registered count only. There is no combinational path from out_ready.
  - When full, a simultaneous pop does not enable a push in the same cycle; in_ready rises the cycle after the pop.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- Empty plus push: only the push occurs, because a pop is impossible while out_valid=0.
- Full: in_valid is ignored. The hub holds the word per the valid/ready rule: valid held until ready, data stable while valid.
- almost_full: combinational from registered count.
- max_count:
  - Each cycle, max_count <= max(max_count, next_count).
  - clear_max=1 loads next_count instead, so the clear is not lost while occupancy is nonzero.
  - Values are never larger than DEPTH.
- Ordering: strict FIFO, with no reordering or dropping. Words are bit-exact, including the destination field.
- Protocol obligations: the upstream must not change in_data while in_valid=1 and in_ready=0. The implementation must not rely on this.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> in_ready=1, out_valid=0, count=0, max_count=0, out_data=0.
- Single word: push 64'hA5A5_0000_0000_0001 with out_ready=0 -> count=1 and out_valid=1 next cycle, out_data equal to the word; raise out_ready -> one pop, count=0, out_valid=0.
- Fill to full (DEPTH=8): push 8 words 1..8 with out_ready=0 -> almost_full=1 at count=6, in_ready=0 at count=8, 9th word held off. Drain -> words emerge 1..8 in order; in_ready=1 the cycle after the first pop.
- Simultaneous push/pop at count=3 for 20 cycles -> count stays 3, pointers wrap past 7→0, output sequence intact with no gaps or duplicates.
- High-water: reach count=5, drain to 2 -> max_count=5; pulse clear_max at count=2 -> max_count=2 next cycle; push to 4 -> max_count=4.
- Reset mid-burst: assert reset at count=4 asynchronously between edges -> outputs immediately count=0, out_valid=0, in_ready=1. After release, new word 64'h1 is the first word out.
